// File: rtl/grant_decoder_3_8_if.sv
// Handshake bundle between the upstream priority encoder and the grant decoder.
//   in_valid : upstream presents a winning index this cycle
//   in_code  : winning index 0..7
//   in_ready : decoder can accept an index this cycle
// master = upstream encoder side, slave = grant decoder side.
interface grant_decoder_3_8_if;
   logic       in_valid;
   logic [2:0] in_code;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_code,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_code,
      output in_ready
   );
endinterface

// File: rtl/grant_decoder_3_8.sv
// Sequential 3-to-8 grant decoder. Accepts a winning index over a
// valid/ready handshake, drives a one-hot grant to the selected line and
// holds it until that line reports done or a TIMEOUT-cycle hold expires.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : low blocks acceptance and aborts an active grant
//   bus (slave)    : in_valid / in_code / in_ready handshake
//   grant          : one-hot grant, zero when idle
//   grant_code     : registered copy of the accepted index
//   busy           : a grant is active
//   done           : per-line completion, only done[grant_code] observed
//   done_pulse     : one cycle, grant ended by done
//   timeout_pulse  : one cycle, grant ended by timeout
module grant_decoder_3_8 #(
   parameter int TIMEOUT = 16,
   parameter int TW      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   grant_decoder_3_8_if.slave  bus,
   output logic [7:0]          grant,
   output logic [2:0]          grant_code,
   output logic                busy,
   input  logic [7:0]          done,
   output logic                done_pulse,
   output logic                timeout_pulse
);

   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [7:0]    grant_nxt;
   logic [2:0]    code_nxt;
   logic          busy_nxt;
   logic          done_pulse_nxt;
   logic          timeout_pulse_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          accept;
   logic          line_done;

   assign bus.in_ready = (state == IDLE) && enable;
   assign accept       = bus.in_valid && bus.in_ready;
   // Only the granted line's completion matters; other done bits are noise.
   assign line_done    = done[grant_code];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         grant         <= 8'h00;
         grant_code    <= 3'd0;
         busy          <= 1'b0;
         done_pulse    <= 1'b0;
         timeout_pulse <= 1'b0;
         timer         <= '0;
      end else begin
         state         <= state_nxt;
         grant         <= grant_nxt;
         grant_code    <= code_nxt;
         busy          <= busy_nxt;
         done_pulse    <= done_pulse_nxt;
         timeout_pulse <= timeout_pulse_nxt;
         timer         <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      grant_nxt         = grant;
      code_nxt          = grant_code;
      busy_nxt          = busy;
      timer_nxt         = timer;
      done_pulse_nxt    = 1'b0;
      timeout_pulse_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               code_nxt  = bus.in_code;
               grant_nxt = 8'b1 << bus.in_code;
               busy_nxt  = 1'b1;
               timer_nxt = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            // Priority: abort, then done, then timeout; done beats a
            // coincident timeout.
            if (!enable) begin
               grant_nxt = 8'h00;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (line_done) begin
               grant_nxt      = 8'h00;
               busy_nxt       = 1'b0;
               done_pulse_nxt = 1'b1;
               state_nxt      = IDLE;
            end else if (timer == TIMER_LAST) begin
               grant_nxt         = 8'h00;
               busy_nxt          = 1'b0;
               timeout_pulse_nxt = 1'b1;
               state_nxt         = IDLE;
            end else if (timer != TIMER_MAX) begin
               timer_nxt = timer + TW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 8'h00;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/grant_decoder_3_8.md
Name: grant_decoder_3_8

Overview:
- Sequential 3-to-8 grant decoder; the consumer end of the 8-to-3 priority encoder path.
- Accepts a 3-bit winning index over a valid/ready handshake and decodes it to a one-hot grant on one of eight lines.
- Holds the grant until the selected line reports done, or until a timeout expires.
- Sits between the request priority encoder and the eight requesting units.

Parameters:
- TIMEOUT, 16, grant-hold cycles before the grant is forcibly revoked; legal range 2..255.
- TW, 8, timer width in bits; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  block enable; low blocks acceptance and aborts any active grant.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  3  index to grant (0..7).
- in_ready  output  1  block can accept a code this cycle.
- grant  output  8  one-hot grant; bit k = 1 means line k is granted.
- grant_code  output  3  registered copy of the accepted index.
- busy  output  1  a grant is active.
- done  input  8  per-line completion; only the bit of the granted line is observed.
- done_pulse  output  1  one-cycle pulse when a grant ends by done.
- timeout_pulse  output  1  one-cycle pulse when a grant ends by timeout.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, grant=8'h00, grant_code=3'd0, busy=0, done_pulse=0, timeout_pulse=0, timer=0.
- Reset asserted mid-grant clears grant immediately and emits no pulse.
- in_ready is combinational: 1 only in state IDLE with enable=1.
- FSM has two states, IDLE and GRANT.
- IDLE behaviour:
  - On a rising edge with in_valid & in_ready: grant_code<=in_code, grant<=(8'b1<<in_code), busy<=1, timer<=0, state->GRANT.
  - The grant is visible one cycle after the accepting edge.
  - in_code is sampled only on an accepting edge; otherwise it is ignored.
- GRANT behaviour, evaluated each edge in this priority order:
  - enable=0: grant<=0, busy<=0, state->IDLE, no pulse (abort).
  - done[grant_code]=1: grant<=0, busy<=0, done_pulse<=1 for one cycle, state->IDLE.
  - timer==TIMEOUT-1: grant<=0, busy<=0, timeout_pulse<=1 for one cycle, state->IDLE.
  - Otherwise: timer<=timer+1. The timer saturates and never wraps.
- If done and timeout coincide on the same edge, done wins and there is no timeout_pulse.
- done bits other than done[grant_code] are ignored in all states; done in IDLE is ignored.
- in_valid while busy is not accepted, since in_ready=0. The upstream must hold the code.
- Back-to-back throughput: after the release edge the block is IDLE and in_ready=1 in the next cycle. Minimum spacing is grant-end edge, then accept edge, then new grant visible. At most one grant is live at any time.
- Invariants: grant is zero or exactly one-hot; grant!=0 iff busy; done_pulse and timeout_pulse are never high together.
- Reachable timeout bound: grant stays high exactly TIMEOUT cycles when no done arrives.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with enable=1 -> grant=0, busy=0, in_ready=1, both pulses 0.
- Basic decode: for in_code 0..7, present in_valid=1 for one accepted cycle, then drive done[k] two cycles later.
  - Required: grant=8'h01,8'h02,...,8'h80 one cycle after accept.
  - Required: grant_code=k.
  - Required: done_pulse for exactly one cycle.
  - Required: grant=0 the cycle after done.
- Wrong-line done and timeout: accept code 5 with TIMEOUT=16 and assert done[2] continuously.
  - Required: grant=8'h20 held for exactly 16 cycles.
  - Required: timeout_pulse=1 for one cycle, done_pulse stays 0.
- Done/timeout collision: accept code 3 and assert done[3] on the same edge where timer==15.
  - Required: done_pulse=1, timeout_pulse=0.
- Backpressure and abort:
  - Accept code 6, then hold in_valid=1 with code 1 during the grant -> in_ready=0 and code 1 is not accepted.
  - Drop enable for one cycle -> grant=0, busy=0, no pulse.
  - Raise enable -> code 1 accepted, grant=8'h02.
- Async reset mid-grant: accept code 7, then pull rst_n low between clock edges -> grant=0 immediately without waiting for an edge, and no pulses.
